// File: rtl/inst_assembler.sv
`default_nettype none
// ============================================================================
// Module      : inst_assembler
// Description : Console-side instruction assembler. Takes one line of
//               assembly text as an ASCII character stream and produces the
//               encoded 32-bit instruction word for this core's field layout:
//                 wd[31:27] rs1[26:22] rs2[21:17] imm12[21:10]
//                 imm20[26:7] funct3[9:7] opcode[6:0]
// Ports       : clk, reset        - clock, synchronous active-high reset
//               char_in/valid     - ASCII character stream (input)
//               char_ready        - low exactly while a result is held
//               inst/inst_err     - encoded word, or error flag with inst=0
//               inst_valid/ready  - result handshake
// Options     : define ASM_MULDIV_EN to accept mul/mulh/mulhsu/mulhu/
//               div/divu/rem/remu as R-type mnemonics.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_assembler #(
  parameter int MNEM_LEN = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [31:0] inst,
  output logic        inst_err,
  output logic        inst_valid,
  input  logic        inst_ready
);

  localparam int LW = $clog2(MNEM_LEN + 8);

  localparam logic [6:0] c_opcode_op     = 7'h33;
  localparam logic [6:0] c_opcode_op_imm = 7'h13;
  localparam logic [6:0] c_opcode_lui    = 7'h37;
  localparam logic [2:0] c_f3_add  = 3'd0;
  localparam logic [2:0] c_f3_sll  = 3'd1;
  localparam logic [2:0] c_f3_slt  = 3'd2;
  localparam logic [2:0] c_f3_sltu = 3'd3;
  localparam logic [2:0] c_f3_xor  = 3'd4;
  localparam logic [2:0] c_f3_srl  = 3'd5;
  localparam logic [2:0] c_f3_or   = 3'd6;
  localparam logic [2:0] c_f3_and  = 3'd7;
`ifdef ASM_MULDIV_EN
  localparam logic [2:0] c_f3_mul    = 3'd0;
  localparam logic [2:0] c_f3_mulh   = 3'd1;
  localparam logic [2:0] c_f3_mulhsu = 3'd2;
  localparam logic [2:0] c_f3_mulhu  = 3'd3;
  localparam logic [2:0] c_f3_div    = 3'd4;
  localparam logic [2:0] c_f3_divu   = 3'd5;
  localparam logic [2:0] c_f3_rem    = 3'd6;
  localparam logic [2:0] c_f3_remu   = 3'd7;
`endif

  typedef enum logic [2:0] {K_BAD, K_R, K_I, K_SH, K_LUI, K_NOP} kind_t;
  typedef enum logic [2:0] {S_MNEM, S_WS, S_REG, S_IMM, S_SEP, S_ERR, S_OUT} state_t;

  state_t        r_state, w_state;
  logic [47:0]   r_key, w_key;       // last six mnemonic chars, right-justified
  logic [LW-1:0] r_mlen, w_mlen;
  logic [1:0]    r_done, w_done;     // operands completed so far
  logic [4:0]    r_rd, r_rs1, r_rs2, w_rd, w_rs1, w_rs2;
  logic [19:0]   r_imm, w_imm, r_acc, w_acc;
  logic          r_neg, w_neg;
  logic [1:0]    r_phase, w_phase;   // immediate: 0 want '0', 1 want 'x', 2 digits
  logic [2:0]    r_dcnt, w_dcnt;
  logic [6:0]    r_regv, w_regv;
  logic [31:0]   r_inst;
  logic          r_err;

  // Character classification after case folding
  logic [7:0] w_c;
  logic       w_ws, w_cr, w_lf, w_letter, w_dig, w_hex;
  logic [3:0] w_hexv;
  always_comb begin
    w_c      = (char_in >= "A" && char_in <= "Z") ? (char_in | 8'h20) : char_in;
    w_ws     = (w_c == " ") || (w_c == 8'h09);
    w_cr     = (w_c == 8'h0D);
    w_lf     = (w_c == 8'h0A);
    w_letter = (w_c >= "a") && (w_c <= "z");
    w_dig    = (w_c >= "0") && (w_c <= "9");
    w_hex    = w_dig || ((w_c >= "a") && (w_c <= "f"));
    // 'a'..'f' have low nibble 1..6
    w_hexv   = w_dig ? w_c[3:0] : (w_c[3:0] + 4'd9);
  end

  // Mnemonic decode
  kind_t      w_kind;
  logic [2:0] w_f3;
  logic       w_b16, w_b10;
  logic [1:0] w_nops;
  always_comb begin
    w_kind = K_BAD;
    w_f3   = c_f3_add;
    w_b16  = 1'b0;
    w_b10  = 1'b0;
    case (r_key)
      {24'h0, "add"}:  begin w_kind = K_R; w_f3 = c_f3_add; end
      {24'h0, "sub"}:  begin w_kind = K_R; w_f3 = c_f3_add; w_b16 = 1'b1; end
      {24'h0, "sll"}:  begin w_kind = K_R; w_f3 = c_f3_sll; end
      {24'h0, "slt"}:  begin w_kind = K_R; w_f3 = c_f3_slt; end
      {16'h0, "sltu"}: begin w_kind = K_R; w_f3 = c_f3_sltu; end
      {24'h0, "xor"}:  begin w_kind = K_R; w_f3 = c_f3_xor; end
      {24'h0, "srl"}:  begin w_kind = K_R; w_f3 = c_f3_srl; end
      {24'h0, "sra"}:  begin w_kind = K_R; w_f3 = c_f3_srl; w_b16 = 1'b1; end
      {32'h0, "or"}:   begin w_kind = K_R; w_f3 = c_f3_or; end
      {24'h0, "and"}:  begin w_kind = K_R; w_f3 = c_f3_and; end
      {16'h0, "addi"}: begin w_kind = K_I; w_f3 = c_f3_add; end
      {16'h0, "slti"}: begin w_kind = K_I; w_f3 = c_f3_slt; end
      {8'h0, "sltiu"}: begin w_kind = K_I; w_f3 = c_f3_sltu; end
      {16'h0, "xori"}: begin w_kind = K_I; w_f3 = c_f3_xor; end
      {24'h0, "ori"}:  begin w_kind = K_I; w_f3 = c_f3_or; end
      {16'h0, "andi"}: begin w_kind = K_I; w_f3 = c_f3_and; end
      {16'h0, "slli"}: begin w_kind = K_SH; w_f3 = c_f3_sll; end
      {16'h0, "srli"}: begin w_kind = K_SH; w_f3 = c_f3_srl; end
      {16'h0, "srai"}: begin w_kind = K_SH; w_f3 = c_f3_srl; w_b16 = 1'b1; end
      {24'h0, "lui"}:  w_kind = K_LUI;
      {24'h0, "nop"}:  w_kind = K_NOP;
`ifdef ASM_MULDIV_EN
      {24'h0, "mul"}:  begin w_kind = K_R; w_f3 = c_f3_mul;    w_b10 = 1'b1; end
      {16'h0, "mulh"}: begin w_kind = K_R; w_f3 = c_f3_mulh;   w_b10 = 1'b1; end
      {"mulhsu"}:      begin w_kind = K_R; w_f3 = c_f3_mulhsu; w_b10 = 1'b1; end
      {8'h0, "mulhu"}: begin w_kind = K_R; w_f3 = c_f3_mulhu;  w_b10 = 1'b1; end
      {24'h0, "div"}:  begin w_kind = K_R; w_f3 = c_f3_div;    w_b10 = 1'b1; end
      {16'h0, "divu"}: begin w_kind = K_R; w_f3 = c_f3_divu;   w_b10 = 1'b1; end
      {24'h0, "rem"}:  begin w_kind = K_R; w_f3 = c_f3_rem;    w_b10 = 1'b1; end
      {16'h0, "remu"}: begin w_kind = K_R; w_f3 = c_f3_remu;   w_b10 = 1'b1; end
`endif
      default:         w_kind = K_BAD;
    endcase
    // The key only keeps six chars, so a longer word could alias a real one
    if (r_mlen > LW'(6)) w_kind = K_BAD;
    case (w_kind)
      K_R, K_I, K_SH: w_nops = 2'd3;
      K_LUI:          w_nops = 2'd2;
      default:        w_nops = 2'd0;
    endcase
  end

  // Operand finalisation helpers
  logic        w_want_imm, w_reg_ok, w_imm_ok, w_fin_ok;
  logic [2:0]  w_maxd;
  logic [1:0]  w_done_inc;
  logic [19:0] w_imm_val;
  always_comb begin
    w_want_imm = (((w_kind == K_I) || (w_kind == K_SH)) && (r_done == 2'd2)) ||
                 ((w_kind == K_LUI) && (r_done == 2'd1));
    w_maxd     = (w_kind == K_LUI) ? 3'd5 : 3'd3;
    w_reg_ok   = (r_dcnt != 3'd0) && (r_regv <= 7'd31);
    w_imm_ok   = (r_dcnt != 3'd0) && ((w_kind != K_SH) || (r_acc <= 20'h0003F));
    w_fin_ok   = (r_state == S_REG) ? w_reg_ok : w_imm_ok;
    w_done_inc = r_done + 2'd1;
    w_imm_val  = r_neg ? (~r_acc + 20'd1) : r_acc;
  end

  // Next-state logic
  logic w_emit, w_emit_err, w_store, w_term, w_fail;
  always_comb begin
    w_state = r_state;  w_key = r_key;   w_mlen = r_mlen;  w_done = r_done;
    w_rd = r_rd;        w_rs1 = r_rs1;   w_rs2 = r_rs2;    w_imm = r_imm;
    w_acc = r_acc;      w_neg = r_neg;   w_phase = r_phase;
    w_dcnt = r_dcnt;    w_regv = r_regv;
    w_emit = 1'b0;  w_emit_err = 1'b0;  w_store = 1'b0;
    w_term = 1'b0;  w_fail = 1'b0;

    if (r_state == S_OUT) begin
      if (inst_ready) begin
        w_state = S_MNEM;
        w_key   = '0;
        w_mlen  = '0;
        w_done  = 2'd0;
      end
    end else if (char_valid && !w_cr) begin
      case (r_state)
        S_MNEM: begin
          if (w_letter) begin
            if (r_mlen == LW'(MNEM_LEN)) w_state = S_ERR;
            else begin
              w_key  = {r_key[39:0], w_c};
              w_mlen = r_mlen + 1'b1;
            end
          end else if (w_ws) begin
            if (r_mlen != '0) begin
              if (w_kind == K_BAD)      w_state = S_ERR;
              else if (w_kind == K_NOP) w_state = S_SEP;
              else                      w_state = S_WS;
            end
          end else if (w_lf) begin
            // blank line produces nothing
            if (r_mlen != '0) begin
              w_emit     = 1'b1;
              w_emit_err = (w_kind != K_NOP);
            end
          end else w_fail = 1'b1;
        end
        S_WS: begin
          if (w_ws) begin
            // skip
          end else if (w_want_imm) begin
            w_acc  = '0;
            w_dcnt = 3'd0;
            if ((w_c == "-") && (w_kind == K_I)) begin
              w_neg = 1'b1;  w_phase = 2'd0;  w_state = S_IMM;
            end else if (w_c == "0") begin
              w_neg = 1'b0;  w_phase = 2'd1;  w_state = S_IMM;
            end else w_fail = 1'b1;
          end else if (w_c == "x") begin
            w_regv  = '0;
            w_dcnt  = 3'd0;
            w_state = S_REG;
          end else w_fail = 1'b1;
        end
        S_REG: begin
          if (w_dig) begin
            if (r_dcnt == 3'd2) w_fail = 1'b1;
            else begin
              w_regv = r_regv * 7'd10 + {3'b000, w_hexv};
              w_dcnt = r_dcnt + 3'd1;
            end
          end else w_term = 1'b1;
        end
        S_IMM: begin
          case (r_phase)
            2'd0:    if (w_c == "0") w_phase = 2'd1; else w_fail = 1'b1;
            2'd1:    if (w_c == "x") w_phase = 2'd2; else w_fail = 1'b1;
            default: begin
              if (w_hex) begin
                if (r_dcnt == w_maxd) w_fail = 1'b1;
                else begin
                  w_acc  = {r_acc[15:0], w_hexv};
                  w_dcnt = r_dcnt + 3'd1;
                end
              end else w_term = 1'b1;
            end
          endcase
        end
        S_SEP: begin
          if (w_ws) begin
            // trailing whitespace allowed
          end else if ((w_c == ",") && (r_done < w_nops)) w_state = S_WS;
          else if (w_lf && (r_done == w_nops)) w_emit = 1'b1;
          else w_fail = 1'b1;
        end
        S_ERR: begin
          if (w_lf) begin
            w_emit     = 1'b1;
            w_emit_err = 1'b1;
          end
        end
        default: w_state = S_MNEM;
      endcase

      // An operand ends on whitespace, ',' or LF
      if (w_term) begin
        if (w_ws && w_fin_ok) begin
          w_store = 1'b1;  w_state = S_SEP;
        end else if ((w_c == ",") && w_fin_ok && (w_done_inc < w_nops)) begin
          w_store = 1'b1;  w_state = S_WS;
        end else if (w_lf && w_fin_ok && (w_done_inc == w_nops)) begin
          w_store = 1'b1;  w_emit = 1'b1;
        end else w_fail = 1'b1;
      end

      if (w_store) begin
        w_done = w_done_inc;
        if (r_state == S_IMM) w_imm = w_imm_val;
        else begin
          case (r_done)
            2'd0:    w_rd  = r_regv[4:0];
            2'd1:    w_rs1 = r_regv[4:0];
            default: w_rs2 = r_regv[4:0];
          endcase
        end
      end

      // A bad character on the LF itself closes the line immediately
      if (w_fail) begin
        if (w_lf) begin
          w_emit     = 1'b1;
          w_emit_err = 1'b1;
        end else w_state = S_ERR;
      end

      if (w_emit) w_state = S_OUT;
    end
  end

  // Encoder, fed from the next-cycle field values so the final operand
  // finalised on the LF cycle is included
  logic [31:0] w_enc;
  always_comb begin
    case (w_kind)
      K_R:     w_enc = {w_rd, w_rs1, w_rs2, w_b16, 5'b00000, w_b10, w_f3, c_opcode_op};
      K_I:     w_enc = {w_rd, w_rs1, w_imm[11:0], w_f3, c_opcode_op_imm};
      K_SH:    w_enc = {w_rd, w_rs1, 5'b00000, w_b16, w_imm[5:0], w_f3, c_opcode_op_imm};
      K_LUI:   w_enc = {w_rd, w_imm, c_opcode_lui};
      default: w_enc = {25'd0, c_opcode_op_imm};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_MNEM;  r_key <= '0;   r_mlen <= '0;   r_done <= 2'd0;
      r_rd <= '0;         r_rs1 <= '0;   r_rs2 <= '0;    r_imm <= '0;
      r_acc <= '0;        r_neg <= 1'b0; r_phase <= 2'd0;
      r_dcnt <= 3'd0;     r_regv <= '0;  r_inst <= '0;   r_err <= 1'b0;
    end else begin
      r_state <= w_state;  r_key <= w_key;  r_mlen <= w_mlen;  r_done <= w_done;
      r_rd <= w_rd;        r_rs1 <= w_rs1;  r_rs2 <= w_rs2;    r_imm <= w_imm;
      r_acc <= w_acc;      r_neg <= w_neg;  r_phase <= w_phase;
      r_dcnt <= w_dcnt;    r_regv <= w_regv;
      if (w_emit) begin
        r_inst <= w_emit_err ? 32'd0 : w_enc;
        r_err  <= w_emit_err;
      end else if ((r_state == S_OUT) && inst_ready) begin
        r_inst <= '0;
        r_err  <= 1'b0;
      end
    end
  end

  assign inst       = r_inst;
  assign inst_err   = r_err;
  assign inst_valid = (r_state == S_OUT);
  assign char_ready = (r_state != S_OUT);

endmodule
`default_nettype wire

// File: tb/tb_inst_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_assembler
// Description : Self-checking bench for inst_assembler. Expected results are
//               queued as each line is sent and popped when the result shows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_assembler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  char_in = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [31:0] inst;
  logic        inst_err;
  logic        inst_valid;
  logic        inst_ready = 1'b0;

  int total = 0;
  int bad = 0;
  logic [32:0] sb[$];   // {inst_err, inst}

  inst_assembler #(.MNEM_LEN(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .inst       (inst),
    .inst_err   (inst_err),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready)
  );

  always #5 clk = ~clk;

  task automatic send_char(input logic [7:0] c);
    int n = 0;
    char_in    = c;
    char_valid = 1'b1;
    while (char_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (char_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL char_stall: char_ready=%b want 1", char_ready);
    end
    @(posedge clk); #1;
    char_valid = 1'b0;
  endtask

  task automatic run_line(input string name, input string s, input bit exp_out,
                          input logic exp_err, input logic [31:0] exp_inst);
    logic [32:0] e;
    int n = 0;
    if (exp_out) sb.push_back({exp_err, exp_inst});
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
    if (exp_out) begin
      total++;
      if (inst_valid !== 1'b1) begin
        bad++;
        $display("FAIL %s_latency: inst_valid=%b want 1 right after LF", name, inst_valid);
      end
      while (inst_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      e = sb.pop_front();
      total++;
      if ({inst_err, inst} !== e) begin
        bad++;
        $display("FAIL %s: got err=%b inst=%h want err=%b inst=%h",
                 name, inst_err, inst, e[32], e[31:0]);
      end
      inst_ready = 1'b1;
      @(posedge clk); #1;
      inst_ready = 1'b0;
      total++;
      if (inst_valid !== 1'b0 || char_ready !== 1'b1) begin
        bad++;
        $display("FAIL %s_release: inst_valid=%b char_ready=%b want 0/1",
                 name, inst_valid, char_ready);
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (inst_valid !== 1'b0) begin
          bad++;
          $display("FAIL %s_quiet: inst_valid=%b want 0", name, inst_valid);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    char_valid = 1'b0;
    inst_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (char_ready !== 1'b1 || inst_valid !== 1'b0 || inst !== 32'd0 || inst_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: ready=%b valid=%b inst=%h err=%b want 1/0/0/0",
               char_ready, inst_valid, inst, inst_err);
    end
  endtask

  task automatic test_rtype();
    run_line("add",  "add x3, x1, x2\n", 1, 1'b0, 32'h18440033);
    run_line("sub",  "SUB x3,x1,x2\015\n", 1, 1'b0, 32'h18450033);
    run_line("sra",  "sra\tx31 ,x2,  x17\n", 1, 1'b0, 32'hF8A302B3);
  endtask

  task automatic test_imm();
    run_line("addi_neg", "addi x5, x0, -0x1\n", 1, 1'b0, 32'h283FFC13);
    run_line("nop",      "nop\n", 1, 1'b0, 32'h00000013);
    // rd=1 at [31:27], 0x12345 at [26:7], LUI opcode 0x37
    run_line("lui",      "lui x1, 0x12345\n", 1, 1'b0, 32'h0891A2B7);
    run_line("srai",     "srai x2, x3, 0x3F\n", 1, 1'b0, 32'h10C1FE93);
    run_line("xori_ws",  "xori x7 , x8 , 0xabc \t\n", 1, 1'b0, 32'h3A2AF213);
  endtask

  task automatic test_errors();
    run_line("reg32",     "add x32, x1, x2\n", 1, 1'b1, 32'd0);
    run_line("imm_big",   "addi x1, x1, 0x1000\n", 1, 1'b1, 32'd0);
    run_line("shamt_big", "slli x1, x1, 0x40\n", 1, 1'b1, 32'd0);
    run_line("unknown",   "foo x1\n", 1, 1'b1, 32'd0);
    run_line("too_few",   "add x1, x2\n", 1, 1'b1, 32'd0);
    run_line("nop_arg",   "nop x1\n", 1, 1'b1, 32'd0);
    run_line("extra",     "add x1, x2, x3 x4\n", 1, 1'b1, 32'd0);
    run_line("no_0x",     "addi x1, x2, 12\n", 1, 1'b1, 32'd0);
    run_line("lui_neg",   "lui x1, -0x1\n", 1, 1'b1, 32'd0);
    run_line("too_long",  "abcdefghi x1\n", 1, 1'b1, 32'd0);
    run_line("lui_6dig",  "lui x1, 0x123456\n", 1, 1'b1, 32'd0);
    run_line("blank",     "\n", 0, 1'b0, 32'd0);
  endtask

  task automatic test_backpressure();
    logic [32:0] e;
    sb.push_back({1'b0, 32'h00000013});
    send_char("n"); send_char("o"); send_char("p"); send_char(8'h0A);
    e = sb.pop_front();
    // hold the first char of the next line while the result is stalled
    char_in    = "n";
    char_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      total++;
      if (inst_valid !== 1'b1 || {inst_err, inst} !== e || char_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold_%0d: valid=%b err=%b inst=%h ready=%b want 1/%b/%h/0",
                 k, inst_valid, inst_err, inst, char_ready, e[32], e[31:0]);
      end
      @(posedge clk); #1;
    end
    inst_ready = 1'b1;
    @(posedge clk); #1;
    inst_ready = 1'b0;
    total++;
    if (char_ready !== 1'b1 || inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL hold_release: ready=%b valid=%b want 1/0", char_ready, inst_valid);
    end
    @(posedge clk); #1;
    char_valid = 1'b0;
    run_line("held_char", "op\n", 1, 1'b0, 32'h00000013);
  endtask

  task automatic test_reset_midline();
    string s = "add x3,";
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
    do_reset();
    total++;
    if (char_ready !== 1'b1 || inst_valid !== 1'b0 || inst !== 32'd0 || inst_err !== 1'b0) begin
      bad++;
      $display("FAIL midline_reset: ready=%b valid=%b inst=%h err=%b want 1/0/0/0",
               char_ready, inst_valid, inst, inst_err);
    end
    run_line("after_reset", "nop\n", 1, 1'b0, 32'h00000013);
  endtask

  task automatic test_muldiv();
`ifdef ASM_MULDIV_EN
    run_line("mul",  "mul x3, x1, x2\n", 1, 1'b0, 32'h18440433);
    run_line("divu", "divu x1, x2, x3\n", 1, 1'b0, 32'h088606B3);
`else
    run_line("mul",  "mul x3, x1, x2\n", 1, 1'b1, 32'd0);
    run_line("divu", "divu x1, x2, x3\n", 1, 1'b1, 32'd0);
`endif
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_imm();
    test_errors();
    test_backpressure();
    test_reset_midline();
    test_muldiv();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
